core_status_monitor: RTL and testbench

Downstream companion to the multi-cycle MIPS core. It consumes the core's per-instruction status stream (`o_status` / `o_status_valid`) and keeps saturating R-type and I-type instruction counters. It buffers every status word in a small FIFO for a host drained by valid/ready, and raises sticky termination flags once the core reports end-of-program or overflow.

---
 rtl/core_status_monitor.sv | 167 ++++++++++++++++
 tb/tb_core_status_monitor.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/core_status_monitor.sv
// core_status_monitor
// Watches the per-instruction status stream of the multi-cycle MIPS core.
// It counts R-type and I-type completions with saturating counters and
// buffers every status code in a small circular FIFO that a host drains
// with valid/ready. It stops accepting input once the core reports
// overflow or end-of-program, lets the host empty the FIFO, then halts.
module core_status_monitor #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [1:0]               i_status,
    input  logic                     i_status_valid,
    output logic [1:0]               o_out_status,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic [CNT_W-1:0]         o_r_count,
    output logic [CNT_W-1:0]         o_i_count,
    output logic [$clog2(DEPTH):0]   o_fifo_level,
    output logic                     o_drop,
    output logic                     o_overflow,
    output logic                     o_done
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0]    LVL_FULL = LW'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    localparam logic [1:0] CODE_R_TYPE   = 2'd0;
    localparam logic [1:0] CODE_I_TYPE   = 2'd1;
    localparam logic [1:0] CODE_OVERFLOW = 2'd2;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } StateT;

    StateT            r_state;
    StateT            w_nextState;

    logic [1:0]       r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [LW-1:0]    r_level;

    logic [CNT_W-1:0] r_rCount;
    logic [CNT_W-1:0] r_iCount;
    logic             r_drop;
    logic             r_overflow;

    logic             w_event;
    logic             w_pop;
    logic             w_pushAllowed;
    logic             w_push;

    // Only RUN listens to the core; DRAIN and HALT ignore the input stream.
    // A pop frees a slot in the same cycle, so a full FIFO can still accept
    // a push when the host is taking the head.
    assign w_event       = (r_state == RUN) && i_status_valid;
    assign w_pop         = o_out_valid && i_out_ready;
    assign w_pushAllowed = (r_level != LVL_FULL) || w_pop;
    assign w_push        = w_event && w_pushAllowed;

    assign o_out_valid  = (r_level != '0);
    assign o_out_status = r_mem[r_rdPtr];
    assign o_fifo_level = r_level;
    assign o_r_count    = r_rCount;
    assign o_i_count    = r_iCount;
    assign o_drop       = r_drop;
    assign o_overflow   = r_overflow;
    assign o_done       = (r_state == HALT);

    // State register for the RUN/DRAIN/HALT sequencer.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_nextState;
        end
    end

    // A terminal code (overflow or end, both with the top bit set) ends the
    // run even if its push was dropped; HALT follows one edge after the
    // FIFO has been observed empty while draining.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            RUN: begin
                if (w_event && i_status[1]) begin
                    w_nextState = DRAIN;
                end
            end
            DRAIN: begin
                if (r_level == '0) begin
                    w_nextState = HALT;
                end
            end
            HALT: begin
                w_nextState = HALT;
            end
            default: begin
                w_nextState = RUN;
            end
        endcase
    end

    // Circular FIFO storage, pointers and occupancy. Storage is cleared on
    // reset so the head output reads zero while the FIFO is empty.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_mem[k] <= 2'd0;
            end
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wrPtr] <= i_status;
                r_wrPtr        <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + 1'b1;
            end else if (w_pop && !w_push) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

    // Saturating instruction counters; they count every RUN event whether
    // or not the FIFO had room for it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rCount <= '0;
            r_iCount <= '0;
        end else begin
            if (w_event && (i_status == CODE_R_TYPE) && (r_rCount != CNT_MAX)) begin
                r_rCount <= r_rCount + 1'b1;
            end
            if (w_event && (i_status == CODE_I_TYPE) && (r_iCount != CNT_MAX)) begin
                r_iCount <= r_iCount + 1'b1;
            end
        end
    end

    // Sticky flags: lost status words and core arithmetic overflow.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_drop     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_event && !w_pushAllowed) begin
                r_drop <= 1'b1;
            end
            if (w_event && (i_status == CODE_OVERFLOW)) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_core_status_monitor.sv
// Directed self-checking bench for core_status_monitor. Inputs are driven
// and outputs sampled on the falling clock edge; every head word the host
// accepts is recorded in a queue and compared against hand-computed values.
module tb_core_status_monitor;

    localparam int DEPTH = 8;
    localparam int CNT_W = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic             i_clk;
    logic             i_rst;
    logic [1:0]       i_status;
    logic             i_status_valid;
    logic [1:0]       o_out_status;
    logic             o_out_valid;
    logic             i_out_ready;
    logic [CNT_W-1:0] o_r_count;
    logic [CNT_W-1:0] o_i_count;
    logic [LW-1:0]    o_fifo_level;
    logic             o_drop;
    logic             o_overflow;
    logic             o_done;

    int               assertCount;
    int               failCount;
    logic [1:0]       popped [$];

    core_status_monitor #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_status       (i_status),
        .i_status_valid (i_status_valid),
        .o_out_status   (o_out_status),
        .o_out_valid    (o_out_valid),
        .i_out_ready    (i_out_ready),
        .o_r_count      (o_r_count),
        .o_i_count      (o_i_count),
        .o_fifo_level   (o_fifo_level),
        .o_drop         (o_drop),
        .o_overflow     (o_overflow),
        .o_done         (o_done)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Compare one observed value against its expected value and tally it.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, record the head if the host takes it on the
    // coming edge, then wait until the falling edge after that rising edge.
    task automatic applyStimulus(input logic rst, input logic vld, input logic [1:0] code,
                                 input logic rdy);
        i_rst          = rst;
        i_status_valid = vld;
        i_status       = code;
        i_out_ready    = rdy;
        if (!rst && o_out_valid && rdy) begin
            popped.push_back(o_out_status);
        end
        @(negedge i_clk);
    endtask

    // Check every output against its reset value.
    task automatic checkResetState(input string tag);
        checkOutput({tag, "_level"},  o_fifo_level, 0);
        checkOutput({tag, "_valid"},  o_out_valid, 0);
        checkOutput({tag, "_status"}, o_out_status, 0);
        checkOutput({tag, "_rcnt"},   o_r_count, 0);
        checkOutput({tag, "_icnt"},   o_i_count, 0);
        checkOutput({tag, "_drop"},   o_drop, 0);
        checkOutput({tag, "_ovf"},    o_overflow, 0);
        checkOutput({tag, "_done"},   o_done, 0);
    endtask

    // Keep the host ready until o_done rises, bounded by a cycle budget.
    task automatic drainUntilDone(input string tag);
        int k;
        k = 0;
        while (!o_done && k < 30) begin
            applyStimulus(1'b0, 1'b0, 2'd0, 1'b1);
            k++;
        end
        checkOutput({tag, "_doneReached"}, o_done, 1);
    endtask

    // Directed scenarios in sequence, then the summary line.
    initial begin
        assertCount    = 0;
        failCount      = 0;
        i_rst          = 1'b1;
        i_status       = 2'd0;
        i_status_valid = 1'b0;
        i_out_ready    = 1'b0;
        @(negedge i_clk);

        $display("[TB] reset state");
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0);
        checkResetState("reset");

        $display("[TB] basic stream");
        popped.delete();
        applyStimulus(1'b0, 1'b1, 2'd0, 1'b1);
        checkOutput("basic_latency_valid", o_out_valid, 1);
        applyStimulus(1'b0, 1'b1, 2'd1, 1'b1);
        applyStimulus(1'b0, 1'b1, 2'd0, 1'b1);
        applyStimulus(1'b0, 1'b1, 2'd3, 1'b1);
        checkOutput("basic_level_after_end", o_fifo_level, 1);
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b1);
        checkOutput("basic_level_final_pop", o_fifo_level, 0);
        checkOutput("basic_done_early", o_done, 0);
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b1);
        checkOutput("basic_done", o_done, 1);
        checkOutput("basic_popCount", popped.size(), 4);
        if (popped.size() == 4) begin
            checkOutput("basic_pop0", popped[0], 0);
            checkOutput("basic_pop1", popped[1], 1);
            checkOutput("basic_pop2", popped[2], 0);
            checkOutput("basic_pop3", popped[3], 3);
        end
        checkOutput("basic_rcnt", o_r_count, 2);
        checkOutput("basic_icnt", o_i_count, 1);
        checkOutput("basic_ovf",  o_overflow, 0);
        checkOutput("basic_drop", o_drop, 0);
        applyStimulus(1'b0, 1'b1, 2'd1, 1'b1);
        checkOutput("basic_halt_ignores", o_i_count, 1);

        $display("[TB] full fifo");
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0);
        popped.delete();
        for (int n = 0; n < 8; n++) begin
            applyStimulus(1'b0, 1'b1, 2'd1, 1'b0);
        end
        checkOutput("full_level8", o_fifo_level, 8);
        checkOutput("full_noDropYet", o_drop, 0);
        applyStimulus(1'b0, 1'b1, 2'd1, 1'b0);
        checkOutput("full_levelHeld", o_fifo_level, 8);
        checkOutput("full_drop", o_drop, 1);
        checkOutput("full_icnt", o_i_count, 9);
        for (int n = 0; n < 12; n++) begin
            applyStimulus(1'b0, 1'b0, 2'd0, 1'b1);
        end
        checkOutput("full_drainCount", popped.size(), 8);
        checkOutput("full_emptyAfter", o_fifo_level, 0);

        $display("[TB] full with simultaneous pop");
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0);
        popped.delete();
        for (int n = 0; n < 8; n++) begin
            applyStimulus(1'b0, 1'b1, 2'd1, 1'b0);
        end
        applyStimulus(1'b0, 1'b1, 2'd0, 1'b1);
        checkOutput("fullPop_level", o_fifo_level, 8);
        checkOutput("fullPop_drop", o_drop, 0);
        checkOutput("fullPop_head", o_out_status, 1);
        for (int n = 0; n < 12; n++) begin
            applyStimulus(1'b0, 1'b0, 2'd0, 1'b1);
        end
        checkOutput("fullPop_total", popped.size(), 9);
        if (popped.size() > 0) begin
            checkOutput("fullPop_last", popped[popped.size()-1], 0);
        end

        $display("[TB] overflow termination and wrap");
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0);
        popped.delete();
        for (int n = 0; n < 6; n++) begin
            applyStimulus(1'b0, 1'b1, 2'd1, 1'b0);
        end
        for (int n = 0; n < 6; n++) begin
            applyStimulus(1'b0, 1'b0, 2'd0, 1'b1);
        end
        checkOutput("wrap_emptyMid", o_fifo_level, 0);
        popped.delete();
        applyStimulus(1'b0, 1'b1, 2'd0, 1'b0);
        applyStimulus(1'b0, 1'b1, 2'd0, 1'b0);
        applyStimulus(1'b0, 1'b1, 2'd2, 1'b0);
        checkOutput("wrap_ovf", o_overflow, 1);
        applyStimulus(1'b0, 1'b1, 2'd1, 1'b0);
        checkOutput("wrap_trailIgnored", o_i_count, 6);
        checkOutput("wrap_levelHeld", o_fifo_level, 3);
        checkOutput("wrap_rcnt", o_r_count, 2);
        checkOutput("wrap_notDone", o_done, 0);
        drainUntilDone("wrap");
        checkOutput("wrap_popCount", popped.size(), 3);
        if (popped.size() == 3) begin
            checkOutput("wrap_pop0", popped[0], 0);
            checkOutput("wrap_pop1", popped[1], 0);
            checkOutput("wrap_pop2", popped[2], 2);
        end
        checkOutput("wrap_levelEnd", o_fifo_level, 0);

        $display("[TB] counter saturation");
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0);
        popped.delete();
        for (int n = 0; n < 20; n++) begin
            applyStimulus(1'b0, 1'b1, 2'd0, 1'b1);
        end
        checkOutput("sat_rcnt", o_r_count, 15);
        checkOutput("sat_icnt", o_i_count, 0);
        checkOutput("sat_drop", o_drop, 0);
        checkOutput("sat_level", o_fifo_level, 1);

        $display("[TB] reset mid-drain");
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0);
        popped.delete();
        applyStimulus(1'b0, 1'b1, 2'd1, 1'b0);
        applyStimulus(1'b0, 1'b1, 2'd1, 1'b0);
        applyStimulus(1'b0, 1'b1, 2'd3, 1'b0);
        checkOutput("midRst_levelBefore", o_fifo_level, 3);
        applyStimulus(1'b1, 1'b1, 2'd1, 1'b1);
        checkResetState("midRst");
        applyStimulus(1'b0, 1'b1, 2'd1, 1'b0);
        checkOutput("midRst_icnt", o_i_count, 1);
        checkOutput("midRst_level", o_fifo_level, 1);
        popped.delete();
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b1);
        checkOutput("midRst_popCount", popped.size(), 1);
        if (popped.size() == 1) begin
            checkOutput("midRst_popVal", popped[0], 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
